// File: rtl/jpeg_stream_ctrl.sv
// -----------------------------------------------------------------------------
// jpeg_stream_ctrl
//
// Assembles one JPEG frame onto a 32-bit output word stream: header words
// first, then pre-stuffed scan words, then the residual scan bytes followed by
// the end-of-image marker, zero-filled to the word boundary. Every accepted
// word appears on the output exactly one cycle after it was accepted.
//
// Ports
//   clk_x8_i         single clock, rising edge
//   rst_i            asynchronous, active-high reset
//   start_i          one-cycle pulse, begins a frame (honoured only in IDLE)
//   hdr_data_i       header word, byte 0 in [31:24]
//   hdr_valid_i      header word valid
//   hdr_last_i       final header word of the frame
//   hdr_ready_o      header accepted (high only while in HDR)
//   scan_data_i      stuffed scan word (no backpressure)
//   scan_valid_i     scan word valid
//   scan_done_i      end-of-scan pulse
//   scan_rem_data_i  residual scan bytes, MSB-first
//   scan_rem_len_i   residual byte count, 0..3
//   out_data_o       output word (holds its value on idle cycles)
//   out_valid_o      output word valid
//   out_keep_o       byte enables, bit3 = [31:24]
//   out_last_o       final word of the frame
//   busy_o           high in every state but IDLE
//   done_o           one-cycle pulse, coincident with the final word
//   err_o            sticky protocol error, cleared by start_i
//   byte_cnt_o       bytes emitted this frame, wraps modulo 2^32
// -----------------------------------------------------------------------------
module jpeg_stream_ctrl #(
  parameter int unsigned PIC_PIX_IN_WIDTH = 32,
  parameter logic [15:0] EOI_MARKER       = 16'hFFD9
) (
  input  logic                        clk_x8_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [31:0]                 hdr_data_i,
  input  logic                        hdr_valid_i,
  input  logic                        hdr_last_i,
  output logic                        hdr_ready_o,
  input  logic [31:0]                 scan_data_i,
  input  logic                        scan_valid_i,
  input  logic                        scan_done_i,
  input  logic [31:0]                 scan_rem_data_i,
  input  logic [1:0]                  scan_rem_len_i,
  output logic [PIC_PIX_IN_WIDTH-1:0] out_data_o,
  output logic                        out_valid_o,
  output logic [3:0]                  out_keep_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 byte_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SCAN  = 3'd2,
    TAIL0 = 3'd3,
    TAIL1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_n;

  // Cleared by reset, set by the first start_i: until then every input other
  // than start_i is ignored, including for error reporting.
  logic        armed;

  // At most three residual bytes are ever valid, so the lowest byte lane of
  // scan_rem_data_i is never captured.
  logic [23:0] rem_bytes;
  logic [1:0]  rem_len;
  logic        unused_rem_lsb;

  logic                        emit;
  logic [PIC_PIX_IN_WIDTH-1:0] emit_data;
  logic [3:0]                  emit_keep;
  logic                        emit_last;
  logic                        set_err;
  logic                        clr_frame;
  logic                        cap_rem;
  logic                        done_set;
  logic                        stray_in;

  logic [31:0] tail_data;
  logic [3:0]  tail_keep;
  logic        tail_last;

  assign unused_rem_lsb = ^scan_rem_data_i[7:0];

  // Any scan activity or a closing header word is illegal outside the state
  // that owns it.
  assign stray_in = scan_valid_i | scan_done_i | (hdr_valid_i & hdr_last_i);

  function automatic logic [31:0] keep_bytes(input logic [3:0] k);
    logic [2:0] n;
    n = {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
    return {29'd0, n};
  endfunction

  // Tail word for the current tail state: residual bytes, then the marker,
  // zero-filled. With three residual bytes the marker straddles two words.
  always_comb begin
    tail_data = '0;
    tail_keep = '0;
    tail_last = 1'b0;
    if (state == TAIL1) begin
      tail_data = {EOI_MARKER[7:0], 24'h000000};
      tail_keep = 4'b1000;
      tail_last = 1'b1;
    end else begin
      unique case (rem_len)
        2'd0: begin
          tail_data = {EOI_MARKER, 16'h0000};
          tail_keep = 4'b1100;
          tail_last = 1'b1;
        end
        2'd1: begin
          tail_data = {rem_bytes[23:16], EOI_MARKER, 8'h00};
          tail_keep = 4'b1110;
          tail_last = 1'b1;
        end
        2'd2: begin
          tail_data = {rem_bytes[23:8], EOI_MARKER};
          tail_keep = 4'b1111;
          tail_last = 1'b1;
        end
        default: begin
          tail_data = {rem_bytes, EOI_MARKER[15:8]};
          tail_keep = 4'b1111;
          tail_last = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    emit      = 1'b0;
    emit_data = '0;
    emit_keep = '0;
    emit_last = 1'b0;
    set_err   = 1'b0;
    clr_frame = 1'b0;
    cap_rem   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          clr_frame = 1'b1;
          state_n   = HDR;
        end else if (armed) begin
          set_err = stray_in;
        end
      end

      HDR: begin
        set_err = scan_valid_i | scan_done_i;
        if (hdr_valid_i) begin
          emit      = 1'b1;
          emit_data = hdr_data_i;
          emit_keep = 4'b1111;
          if (hdr_last_i) begin
            state_n = SCAN;
          end
        end
      end

      SCAN: begin
        set_err = hdr_valid_i & hdr_last_i;
        if (scan_valid_i) begin
          emit      = 1'b1;
          emit_data = scan_data_i;
          emit_keep = 4'b1111;
        end
        // A scan word in the same cycle goes out now; the tail follows from
        // TAIL0 on the next cycle, so ordering is preserved.
        if (scan_done_i) begin
          cap_rem = 1'b1;
          state_n = TAIL0;
        end
      end

      TAIL0: begin
        set_err   = stray_in;
        emit      = 1'b1;
        emit_data = tail_data;
        emit_keep = tail_keep;
        emit_last = tail_last;
        state_n   = tail_last ? DONE : TAIL1;
      end

      TAIL1: begin
        set_err   = stray_in;
        emit      = 1'b1;
        emit_data = tail_data;
        emit_keep = tail_keep;
        emit_last = tail_last;
        state_n   = DONE;
      end

      DONE: begin
        set_err = stray_in;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // done_o is registered on the same edge as the final word, so the pulse
  // lines up with out_last_o during the DONE cycle.
  assign done_set = (state_n == DONE);

  always_ff @(posedge clk_x8_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      armed       <= 1'b0;
      rem_bytes   <= '0;
      rem_len     <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      out_keep_o  <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      byte_cnt_o  <= '0;
    end else begin
      state       <= state_n;
      out_valid_o <= emit;
      out_keep_o  <= emit ? emit_keep : 4'b0000;
      out_last_o  <= emit & emit_last;
      done_o      <= done_set;

      if (clr_frame) begin
        armed <= 1'b1;
      end

      if (cap_rem) begin
        rem_bytes <= scan_rem_data_i[31:8];
        rem_len   <= scan_rem_len_i;
      end

      if (emit) begin
        out_data_o <= emit_data;
      end

      if (clr_frame) begin
        byte_cnt_o <= '0;
      end else if (emit) begin
        byte_cnt_o <= byte_cnt_o + keep_bytes(emit_keep);
      end

      if (clr_frame) begin
        err_o <= 1'b0;
      end else if (set_err) begin
        err_o <= 1'b1;
      end
    end
  end

  assign hdr_ready_o = (state == HDR);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_jpeg_stream_ctrl.sv
module tb_jpeg_stream_ctrl;

  logic        clk_x8_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] hdr_data_i;
  logic        hdr_valid_i;
  logic        hdr_last_i;
  logic        hdr_ready_o;
  logic [31:0] scan_data_i;
  logic        scan_valid_i;
  logic        scan_done_i;
  logic [31:0] scan_rem_data_i;
  logic [1:0]  scan_rem_len_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic [3:0]  out_keep_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] byte_cnt_o;

  jpeg_stream_ctrl #(
    .PIC_PIX_IN_WIDTH(32),
    .EOI_MARKER      (16'hFFD9)
  ) dut (
    .clk_x8_i       (clk_x8_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .hdr_data_i     (hdr_data_i),
    .hdr_valid_i    (hdr_valid_i),
    .hdr_last_i     (hdr_last_i),
    .hdr_ready_o    (hdr_ready_o),
    .scan_data_i    (scan_data_i),
    .scan_valid_i   (scan_valid_i),
    .scan_done_i    (scan_done_i),
    .scan_rem_data_i(scan_rem_data_i),
    .scan_rem_len_i (scan_rem_len_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_keep_o     (out_keep_o),
    .out_last_o     (out_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .byte_cnt_o     (byte_cnt_o)
  );

  initial clk_x8_i = 1'b0;
  always #5 clk_x8_i = ~clk_x8_i;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks   = 0;
  int unsigned n_fail     = 0;
  int unsigned done_cnt   = 0;
  logic [31:0] mon_cnt    = '0;
  logic [31:0] last_exp_d = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nbytes(input logic [3:0] k);
    return 32'(k[0]) + 32'(k[1]) + 32'(k[2]) + 32'(k[3]);
  endfunction

  function automatic void push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.d = d; e.k = k; e.l = l;
    sb.push_back(e);
  endfunction

  // Tail words as the residual-length table defines them (marker FF D9).
  function automatic void push_tail(input logic [31:0] rd, input logic [1:0] rl);
    case (rl)
      2'd0: push(32'hFFD90000, 4'b1100, 1'b1);
      2'd1: push({rd[31:24], 24'hFFD900}, 4'b1110, 1'b1);
      2'd2: push({rd[31:16], 16'hFFD9}, 4'b1111, 1'b1);
      default: begin
        push({rd[31:8], 8'hFF}, 4'b1111, 1'b0);
        push(32'hD9000000, 4'b1000, 1'b1);
      end
    endcase
  endfunction

  // Output monitor: every valid word must match the head of the scoreboard.
  always @(negedge clk_x8_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          mon_cnt = mon_cnt + nbytes(e.k);
          last_exp_d = e.d;
          check_val("out_data", out_data_o, e.d);
          check_val("out_keep", 32'(out_keep_o), 32'(e.k));
          check_val("out_last", 32'(out_last_o), 32'(e.l));
          check_val("done_with_last", 32'(done_o), 32'(e.l));
          check_val("byte_cnt_run", byte_cnt_o, mon_cnt);
        end
      end else begin
        check_val("data_hold", out_data_o, last_exp_d);
      end
    end
  end

  task automatic drive(input logic hv, input logic hl, input logic [31:0] hd,
                       input logic sv, input logic [31:0] sd,
                       input logic sdn, input logic [31:0] rd, input logic [1:0] rl);
    hdr_valid_i     = hv;
    hdr_last_i      = hl;
    hdr_data_i      = hd;
    scan_valid_i    = sv;
    scan_data_i     = sd;
    scan_done_i     = sdn;
    scan_rem_data_i = rd;
    scan_rem_len_i  = rl;
    @(negedge clk_x8_i);
    hdr_valid_i  = 1'b0;
    hdr_last_i   = 1'b0;
    scan_valid_i = 1'b0;
    scan_done_i  = 1'b0;
  endtask

  task automatic do_start();
    mon_cnt = '0;
    start_i = 1'b1;
    @(negedge clk_x8_i);
    start_i = 1'b0;
    check_val("start_busy", 32'(busy_o), 32'd1);
    check_val("start_ready", 32'(hdr_ready_o), 32'd1);
    check_val("start_cnt", byte_cnt_o, 32'd0);
    check_val("start_err", 32'(err_o), 32'd0);
  endtask

  task automatic hdr(input logic [31:0] d, input logic last);
    push(d, 4'b1111, 1'b0);
    drive(1'b1, last, d, 1'b0, '0, 1'b0, '0, 2'd0);
  endtask

  task automatic scan(input logic [31:0] d);
    push(d, 4'b1111, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, d, 1'b0, '0, 2'd0);
  endtask

  task automatic scan_end(input logic sv, input logic [31:0] sd,
                          input logic [31:0] rd, input logic [1:0] rl);
    if (sv) push(sd, 4'b1111, 1'b0);
    push_tail(rd, rl);
    drive(1'b0, 1'b0, '0, sv, sd, 1'b1, rd, rl);
  endtask

  task automatic finish_frame(input logic [31:0] exp_bytes, input int unsigned exp_done);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_x8_i);
    check_val("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk_x8_i);
    check_val("end_busy", 32'(busy_o), 32'd0);
    check_val("end_bytes", byte_cnt_o, exp_bytes);
    check_val("done_pulses", done_cnt, exp_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_i = 0; hdr_data_i = '0; hdr_valid_i = 0; hdr_last_i = 0;
    scan_data_i = '0; scan_valid_i = 0; scan_done_i = 0;
    scan_rem_data_i = '0; scan_rem_len_i = '0;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #2;
    check_val("rst_valid", 32'(out_valid_o), 32'd0);
    check_val("rst_data", out_data_o, 32'd0);
    check_val("rst_keep", 32'(out_keep_o), 32'd0);
    check_val("rst_last", 32'(out_last_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_ready", 32'(hdr_ready_o), 32'd0);
    check_val("rst_done", 32'(done_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_cnt", byte_cnt_o, 32'd0);
    @(negedge clk_x8_i);
    rst_i = 1'b0;
    @(negedge clk_x8_i);

    // Stray traffic before the first start is ignored without an error.
    drive(1'b1, 1'b1, 32'h01020304, 1'b1, 32'h05060708, 1'b1, 32'hAABB0000, 2'd2);
    @(negedge clk_x8_i);
    check_val("prestart_err", 32'(err_o), 32'd0);
    check_val("prestart_busy", 32'(busy_o), 32'd0);

    // Frame 1: 3 header words, 2 scan words, residual of 2 bytes.
    do_start();
    hdr(32'h11111111, 1'b0);
    hdr(32'h22222222, 1'b0);
    hdr(32'h33333333, 1'b1);
    scan(32'h44444444);
    scan(32'h55555555);
    scan_end(1'b0, '0, 32'hAABB0000, 2'd2);
    finish_frame(32'd24, 1);

    // Frame 2: scan word and scan_done together, residual of 3 bytes.
    do_start();
    hdr(32'hC0C0C0C0, 1'b1);
    scan_end(1'b1, 32'h66666666, 32'h11223344, 2'd3);
    finish_frame(32'd13, 2);

    // Frame 3: empty scan, marker only.
    do_start();
    hdr(32'hD0D0D0D0, 1'b1);
    scan_end(1'b0, '0, 32'h00000000, 2'd0);
    finish_frame(32'd6, 3);

    // Frame 4: scan word during the header is dropped and flags a sticky error.
    do_start();
    push(32'hA0A0A0A0, 4'b1111, 1'b0);
    drive(1'b1, 1'b0, 32'hA0A0A0A0, 1'b1, 32'hDEADBEEF, 1'b0, '0, 2'd0);
    check_val("err_set", 32'(err_o), 32'd1);
    check_val("err_in_hdr", 32'(hdr_ready_o), 32'd1);
    hdr(32'hA1A1A1A1, 1'b1);
    check_val("err_sticky", 32'(err_o), 32'd1);
    scan_end(1'b0, '0, 32'hCC000000, 2'd1);
    finish_frame(32'd11, 4);
    check_val("err_after", 32'(err_o), 32'd1);

    // Frame 5: reset in SCAN discards the partial frame.
    do_start();
    hdr(32'hB0B0B0B0, 1'b1);
    scan(32'h77777777);
    #2;
    rst_i = 1'b1;
    last_exp_d = '0;
    #1;
    check_val("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check_val("mid_rst_data", out_data_o, 32'd0);
    check_val("mid_rst_keep", 32'(out_keep_o), 32'd0);
    check_val("mid_rst_last", 32'(out_last_o), 32'd0);
    check_val("mid_rst_busy", 32'(busy_o), 32'd0);
    check_val("mid_rst_cnt", byte_cnt_o, 32'd0);
    check_val("mid_rst_sb", 32'(sb.size()), 32'd0);
    @(negedge clk_x8_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_x8_i);
    check_val("post_rst_busy", 32'(busy_o), 32'd0);

    // Frame 6: clean frame after the reset.
    do_start();
    hdr(32'hE0E0E0E0, 1'b1);
    scan(32'h88888888);
    scan_end(1'b0, '0, 32'h12340000, 2'd2);
    finish_frame(32'd12, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
